// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed scan controller for a 4-digit, 7-segment display.
//
// Every digit gets a slot of DIV clock cycles. The first DIV-GAP cycles
// drive the digit and the last GAP cycles blank it. A new display value is
// written into a single pending buffer and moves to the active register only
// at a frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   wr_valid   - requester offers a new 16-bit display value
//   wr_data    - four hex nibbles, [15:12] = digit 3 ... [3:0] = digit 0
//   wr_ready   - pending buffer empty; a write is accepted this cycle
//   blank_lz   - leading-zero blanking enable
//   dp_mask    - decimal-point enable per digit
//   digit      - nibble of the current slot (to the external 7-seg decoder)
//   line       - one-hot digit enable, active-high, registered
//   dp         - decimal point of the current slot, registered
//   frame_done - one-cycle pulse in the last blank cycle of digit 3
module seg7_scan_ctrl #(
    parameter int unsigned DIV = 1000,
    parameter int unsigned GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  digit,
    output logic [3:0]  line,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DIV - GAP - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(GAP - 1);

    typedef enum logic {
        DRIVE,
        BLANK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   active, active_nxt;
    logic [15:0]   pend;
    logic          pend_full;
    logic          boundary;
    logic          accept;
    logic          blk_nxt;
    logic [3:0]    line_nxt;
    logic          dp_nxt;
    logic          frame_done_nxt;

    assign wr_ready = ~pend_full;
    assign accept   = wr_valid & ~pend_full;
    assign digit    = active[{idx, 2'b00} +: 4];

    // Slot sequencing: DRIVE for DIV-GAP cycles, BLANK for GAP cycles,
    // digit index advances when BLANK ends.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        case (state)
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign boundary   = (state == BLANK) && (idx == 2'd3) && (cnt == BLANK_LAST);
    assign active_nxt = (boundary && pend_full) ? pend : active;

    // line/dp/frame_done are registered, so they are computed from the
    // next-cycle slot position and the next-cycle active value.
    always_comb begin
        blk_nxt = 1'b0;
        case (idx_nxt)
            2'd1:    blk_nxt = blank_lz && (active_nxt[15:4]  == '0);
            2'd2:    blk_nxt = blank_lz && (active_nxt[15:8]  == '0);
            2'd3:    blk_nxt = blank_lz && (active_nxt[15:12] == '0);
            default: blk_nxt = 1'b0;
        endcase
    end

    always_comb begin
        line_nxt = '0;
        if (state_nxt == DRIVE && !blk_nxt) begin
            line_nxt = 4'b0001 << idx_nxt;
        end
        dp_nxt         = dp_mask[idx_nxt] && (line_nxt != '0);
        frame_done_nxt = (state_nxt == BLANK) && (idx_nxt == 2'd3) &&
                         (cnt_nxt == BLANK_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd3;
            active     <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            line       <= '0;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            active     <= active_nxt;
            line       <= line_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
            // accept and the boundary load are exclusive: accept needs an
            // empty buffer, the load needs a full one.
            if (accept) begin
                pend      <= wr_data;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with DIV=8, GAP=2.
// A reference model derives the expected outputs from the position within
// the frame (plain arithmetic on a cycle count since reset release).
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit;
    logic [3:0]  line;
    logic        dp;
    logic        frame_done;

    seg7_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .digit      (digit),
        .line       (line),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;

    // reference model state
    logic [15:0] m_act  = '0;
    logic [15:0] m_pend = '0;
    logic        m_pfull = 1'b0;
    logic        lz_prev = 1'b0;
    logic [3:0]  dpm_prev = '0;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [3:0]  dpm;
        logic [3:0]  lit;
        logic [3:0]  dpx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_model();
        int pos, slot, off;
        logic [15:0] sh, el;
        logic blk, edp;
        pos  = (t + FRAME - GAP) % FRAME;
        slot = pos / DIV;
        off  = pos % DIV;
        sh   = m_act >> (4 * slot);
        blk  = lz_prev && (slot > 0) && (sh == 16'h0);
        el   = (off < DIV - GAP && !blk) ? (16'h1 << slot) : 16'h0;
        edp  = dpm_prev[slot] && (el != 16'h0);
        chk("line", 16'(line), el);
        chk("dp", 16'(dp), 16'(edp));
        chk("frame_done", 16'(frame_done), 16'(pos == FRAME - 1));
        chk("digit", 16'(digit), sh & 16'hF);
        chk("wr_ready", 16'(wr_ready), 16'(!m_pfull));
    endtask

    task automatic cycle();
        int  pos;
        logic acc;
        pos = (t + FRAME - GAP) % FRAME;
        acc = wr_valid && !m_pfull;
        if (pos == FRAME - 1 && m_pfull) begin
            m_act   = m_pend;
            m_pfull = 1'b0;
        end
        if (acc) begin
            m_pend  = wr_data;
            m_pfull = 1'b1;
        end
        lz_prev  = blank_lz;
        dpm_prev = dp_mask;
        t++;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_to(input int target);
        while (t < target) cycle();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_line", 16'(line), 16'h0);
        chk("rst_dp", 16'(dp), 16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_wr_ready", 16'(wr_ready), 16'h1);
        chk("rst_digit", 16'(digit), 16'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        t        = 0;
        m_act    = '0;
        m_pend   = '0;
        m_pfull  = 1'b0;
        lz_prev  = blank_lz;
        dpm_prev = dp_mask;
        check_model();
    endtask

    task automatic write_word(input logic [15:0] v);
        int guard;
        guard = 0;
        while (!wr_ready && guard < 200) begin
            cycle();
            guard++;
        end
        chk("write_wait", 16'(wr_ready), 16'h1);
        wr_valid = 1'b1;
        wr_data  = v;
        cycle();
        wr_valid = 1'b0;
        wr_data  = 16'($urandom);
    endtask

    initial begin
        vecs[0] = '{16'h0030, 1'b1, 4'b0100, 4'b0011, 4'b0000};
        vecs[1] = '{16'h0000, 1'b1, 4'b0100, 4'b0001, 4'b0000};
        vecs[2] = '{16'h0000, 1'b0, 4'b0100, 4'b1111, 4'b0100};
        vecs[3] = '{16'h0300, 1'b1, 4'b0100, 4'b0111, 4'b0100};
        vecs[4] = '{16'h12AF, 1'b1, 4'b1001, 4'b1111, 4'b1001};
        vecs[5] = '{16'h000F, 1'b1, 4'b1111, 4'b0001, 4'b0001};

        #12;
        do_reset();

        // blank display after reset: timing of the first frames
        run_to(1);  chk("seq_fd_first", 16'(frame_done), 16'h1);
        run_to(2);  chk("seq_line_d0_start", 16'(line), 16'h1);
        run_to(7);  chk("seq_line_d0_end", 16'(line), 16'h1);
        run_to(8);  chk("seq_line_d0_blank", 16'(line), 16'h0);
        run_to(10); chk("seq_line_d1", 16'(line), 16'h2);
        run_to(18); chk("seq_line_d2", 16'(line), 16'h4);
        run_to(26); chk("seq_line_d3", 16'(line), 16'h8);
        run_to(32); chk("seq_fd_not_yet", 16'(frame_done), 16'h0);
        run_to(33); chk("seq_fd_period", 16'(frame_done), 16'h1);

        // write mid-frame, shown only from the next frame
        run_to(40);
        wr_valid = 1'b1; wr_data = 16'h12AF;
        cycle();
        wr_valid = 1'b0;
        chk("wr_busy", 16'(wr_ready), 16'h0);
        chk("wr_not_shortcut", 16'(digit), 16'h0);
        run_to(66); chk("wr_digit0", 16'(digit), 16'hF);
                    chk("wr_ready_again", 16'(wr_ready), 16'h1);
        run_to(74); chk("wr_digit1", 16'(digit), 16'hA);
        run_to(82); chk("wr_digit2", 16'(digit), 16'h2);
        run_to(90); chk("wr_digit3", 16'(digit), 16'h1);

        // held write while pending is full
        run_to(70) ;
        wr_valid = 1'b1; wr_data = 16'hBEEF;
        cycle();
        wr_valid = 1'b0;
        run_to(75);
        wr_valid = 1'b1; wr_data = 16'h5555;
        run_to(80); chk("hold_refused", 16'(wr_ready), 16'h0);
        run_to(97); chk("hold_fd", 16'(frame_done), 16'h1);
                    chk("hold_still_busy", 16'(wr_ready), 16'h0);
        run_to(98); chk("hold_ready_after", 16'(wr_ready), 16'h1);
                    chk("hold_beef_d0", 16'(digit), 16'hF);
        cycle();
        wr_valid = 1'b0;
        chk("hold_accepted", 16'(wr_ready), 16'h0);
        run_to(106); chk("hold_beef_d1", 16'(digit), 16'hE);
        run_to(130); chk("hold_5555", 16'(digit), 16'h5);

        // blanking / decimal-point table
        foreach (vecs[i]) begin
            int g;
            logic [3:0] el;
            blank_lz = vecs[i].lz;
            dp_mask  = vecs[i].dpm;
            write_word(vecs[i].val);
            g = 0;
            while (!frame_done && g < 200) begin
                cycle();
                g++;
            end
            chk("tbl_frame_wait", 16'(frame_done), 16'h1);
            cycle();
            for (int s = 0; s < 4; s++) begin
                for (int o = 0; o < DIV; o++) begin
                    if (o == 1) begin
                        el = '0;
                        if (vecs[i].lit[s]) el[s] = 1'b1;
                        chk("tbl_line", 16'(line), 16'(el));
                        chk("tbl_dp", 16'(dp), 16'(vecs[i].dpx[s]));
                    end
                    if (o == DIV - 1) begin
                        chk("tbl_blank_line", 16'(line), 16'h0);
                        chk("tbl_blank_dp", 16'(dp), 16'h0);
                    end
                    cycle();
                end
            end
        end

        // reset in the middle of digit 1 with a pending write
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        do_reset();
        run_to(10);
        wr_valid = 1'b1; wr_data = 16'h12AF;
        cycle();
        wr_valid = 1'b0;
        chk("mid_pending", 16'(wr_ready), 16'h0);
        run_to(12); chk("mid_line_d1", 16'(line), 16'h2);
        do_reset();
        run_to(1);  chk("mid_fd_first", 16'(frame_done), 16'h1);
        run_to(2);  chk("mid_line_d0", 16'(line), 16'h1);
        run_to(34); chk("mid_discarded", 16'(digit), 16'h0);
                    chk("mid_ready", 16'(wr_ready), 16'h1);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] d;
            for (int k = 0; k < 4; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            wr_data  = d;
            wr_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            cycle();
        end
        wr_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles per digit slot (legal 4..65535).
REQ-002 SHALL have parameter GAP, default 16: blanking cycles at the end of each slot (legal 1..DIV-2).
REQ-003 SHALL have port clk, input, 1: sole clock, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_valid, input, 1: the requester offers a new display value.
REQ-006 SHALL have port wr_data, input, 16: four hex nibbles; [15:12] is digit 3 (most significant), [3:0] is digit 0.
REQ-007 SHALL have port wr_ready, output, 1: the pending buffer is empty and a write is accepted this cycle.
REQ-008 SHALL have port blank_lz, input, 1: leading-zero blanking enable, sampled every cycle.
REQ-009 SHALL have port dp_mask, input, 4: decimal-point enable per digit, sampled every cycle.
REQ-010 SHALL have port digit, output, 4: nibble for the current slot, feeding the external 7-seg decoder.
REQ-011 SHALL have port line, output, 4: one-hot digit enable, active-high, with bit n selecting digit n.
REQ-012 SHALL have port dp, output, 1: decimal point for the current slot, active-high.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL hold a 16-bit active register (what is displayed) and a 16-bit pending register with a full flag.
REQ-015 SHALL drive wr_ready = ~pend_full combinationally; a write is accepted when wr_valid && wr_ready, capturing wr_data into pending and setting pend_full on that edge.
REQ-016 SHALL keep wr_data as a don't-care when no write is accepted; the requester may hold wr_valid across cycles without penalty.
REQ-017 SHALL implement a two-state FSM per slot: DRIVE (DIV-GAP cycles) then BLANK (GAP cycles), using a slot cycle counter of width ceil(log2(DIV)) that clears at each state change.
REQ-018 SHALL advance the 2-bit digit index modulo 4 (3 wraps to 0) on the BLANK->DRIVE transition.
REQ-019 SHALL define the frame boundary as the last BLANK cycle of digit 3, and in that cycle SHALL pulse frame_done = 1.
REQ-020 SHALL, at the frame boundary with pend_full = 1, copy pending to active and clear pend_full on the same edge.
REQ-021 SHALL, when a write is accepted in the frame-boundary cycle (pend_full = 0), store it in pending only; it is loaded at the next boundary and never shortcut to active.
REQ-022 SHALL drive digit = active nibble of the current index in both DRIVE and BLANK.
REQ-023 SHALL drive line = 4'b0000 in BLANK.
REQ-024 SHALL, in DRIVE, drive line as the one-hot of the index unless the digit is blanked.
REQ-025 SHALL treat digit n as blanked iff blank_lz = 1, n > 0, and the active nibbles n..3 are all zero; digit 0 SHALL never be blanked.
REQ-026 SHALL drive dp = dp_mask[index] && (line != 0).
REQ-027 SHALL make line, dp and frame_done registered outputs (no combinational path from inputs except wr_ready).

Reset
REQ-028 SHALL, on rst_n low, immediately set: active = 16'h0000, pend_full = 0, line = 4'b0000, dp = 0, frame_done = 0, index = 3, state = BLANK, counter = 0.
REQ-029 SHALL make the first boundary after reset release occur GAP cycles later, so that scanning begins with digit 0 DRIVE.
REQ-030 SHALL, on rst_n asserted mid-slot, abandon the slot immediately and discard any pending write; wr_ready = 1 during reset.

Verification (DIV=8, GAP=2)
REQ-031 SHALL cover: release reset, no writes -> frame_done in cycle 1, then line = 0001 for 6 cycles, 0000 for 2, then 0010, 0100, 1000 likewise, with frame period 32 cycles and digit = 0 throughout.
REQ-032 SHALL cover: write 16'h12AF mid-frame -> wr_ready low the next cycle; digit values 4'hF, 4'hA, 4'h2, 4'h1 appear only from the next frame; wr_ready high again after that boundary.
REQ-033 SHALL cover: second write 16'h5555 while pend_full -> wr_ready = 0 and not accepted; held wr_valid is accepted in the cycle after the boundary and displayed one frame later.
REQ-034 SHALL cover: blank_lz = 1 with active = 16'h0030 -> digits 3 and 2 give line = 0000 in DRIVE; digits 1 and 0 drive normally; active = 16'h0000 -> only digit 0 lit.
REQ-035 SHALL cover: dp_mask = 4'b0100 -> dp = 1 only during digit 2 DRIVE and 0 in BLANK; with digit 2 blanked, dp = 0.
REQ-036 SHALL cover: rst_n pulsed low mid-DRIVE of digit 1 with pend_full = 1 -> line = 0000 asynchronously, wr_ready = 1, and after release the REQ-031 sequence repeats with digit = 0.
